write_slave_responder: RTL and testbench

Slave/responder end of the team's valid/ready write channel (valid, ready, addr, data, id, resp). Accepts one master write at a time, inserts a programmable number of wait states, then commits the data to an internal word memory. It completes the transfer with a one-cycle ready pulse that carries a decoded response code. It also provides a registered debug read port, completion counters and a sticky protocol-error flag for the transaction-manager bench.

---
 rtl/write_slave_responder.sv | 164 ++++++++++++++++
 tb/tb_write_slave_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_slave_responder.sv
// Write-channel responder: accepts one valid/ready write, waits WAIT_CYCLES, decodes and commits,
// then pulses ready with a response code. Also provides a registered debug read port and status counters.
module write_slave_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int RO_WORDS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [3:0]            id,
    output logic                  ready,
    output logic [1:0]            resp,
    output logic [3:0]            last_id,
    output logic                  busy,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [15:0]           wr_count,
    output logic [15:0]           err_count,
    output logic                  protocol_err
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] RO_LIM    = (ADDR_WIDTH + 1)'(RO_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [3:0]              id_q;
    logic [1:0]              resp_q;
    logic [3:0]              last_id_q;
    logic [15:0]             wr_count_q;
    logic [15:0]             err_count_q;
    logic                    perr_q;
    logic [DATA_WIDTH-1:0]   dbg_data_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   src_addr;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [3:0]              src_id;
    logic [1:0]              dec_resp;
    logic                    enter_resp;
    logic                    mem_we;
    logic                    abort;

    // With zero wait states the commit happens on the accepting edge, so the live inputs are used.
    assign src_addr = (state_q == S_IDLE) ? addr : addr_q;
    assign src_data = (state_q == S_IDLE) ? data : data_q;
    assign src_id   = (state_q == S_IDLE) ? id   : id_q;

    always_comb begin
        dec_resp = RESP_OKAY;
        if ({1'b0, src_addr} >= DEPTH_LIM)
            dec_resp = RESP_DECERR;
        else if ({1'b0, src_addr} < RO_LIM)
            dec_resp = RESP_SLVERR;
    end

    assign enter_resp = (state_d == S_RESP);
    assign mem_we     = enter_resp && (dec_resp == RESP_OKAY) && !rst;
    assign abort      = (state_q == S_WAIT) && !valid;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (!valid)
                    state_d = S_IDLE;
                else if (cnt_q == '0)
                    state_d = S_RESP;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            id_q        <= '0;
            resp_q      <= RESP_OKAY;
            last_id_q   <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
            perr_q      <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && valid) begin
                addr_q <= addr;
                data_q <= data;
                id_q   <= id;
            end
            if (abort)
                perr_q <= 1'b1;
            if (enter_resp) begin
                resp_q    <= dec_resp;
                last_id_q <= src_id;
                if (dec_resp == RESP_OKAY) begin
                    if (wr_count_q != 16'hFFFF)
                        wr_count_q <= wr_count_q + 16'd1;
                end else if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
            end
            // Reads the pre-edge array, so a same-edge write to this word shows up one cycle later.
            if ({1'b0, dbg_addr} < DEPTH_LIM)
                dbg_data_q <= mem[dbg_addr[IDX_W-1:0]];
            else
                dbg_data_q <= '0;
        end
    end

    // NOTE: the memory array has no reset; only the write enable is gated while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[src_addr[IDX_W-1:0]] <= src_data;
    end

    always_comb begin
        ready = (state_q == S_RESP);
        busy  = (state_q != S_IDLE);
        resp  = ready ? resp_q : RESP_OKAY;
    end

    assign last_id      = last_id_q;
    assign dbg_data     = dbg_data_q;
    assign wr_count     = wr_count_q;
    assign err_count    = err_count_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_write_slave_responder.sv
// Bench for write_slave_responder: table vectors, corner sequences and random writes checked
// against a transaction-level model (address decode, word map, counters).
module tb_write_slave_responder;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int RO    = 4;
    localparam int WC    = 2;

    logic          clk = 1'b0;
    logic          rst;

    logic          valid, ready, busy, protocol_err;
    logic [AW-1:0] addr, dbg_addr;
    logic [DW-1:0] data, dbg_data;
    logic [3:0]    id, last_id;
    logic [1:0]    resp;
    logic [15:0]   wr_count, err_count;

    logic          valid0, ready0, busy0, protocol_err0;
    logic [AW-1:0] addr0, dbg_addr0;
    logic [DW-1:0] data0, dbg_data0;
    logic [3:0]    id0, last_id0;
    logic [1:0]    resp0;
    logic [15:0]   wr_count0, err_count0;

    write_slave_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                            .WAIT_CYCLES(WC), .RO_WORDS(RO)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .data(data), .id(id),
        .ready(ready), .resp(resp), .last_id(last_id), .busy(busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count),
        .err_count(err_count), .protocol_err(protocol_err));

    write_slave_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                            .WAIT_CYCLES(0), .RO_WORDS(RO)) dut0 (
        .clk(clk), .rst(rst), .valid(valid0), .addr(addr0), .data(data0), .id(id0),
        .ready(ready0), .resp(resp0), .last_id(last_id0), .busy(busy0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0), .wr_count(wr_count0),
        .err_count(err_count0), .protocol_err(protocol_err0));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word map of committed writes plus completion bookkeeping.
    logic [DW-1:0] mem_m [int];
    int            exp_wr   = 0;
    int            exp_err  = 0;
    logic [3:0]    exp_last = '0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    i;
        logic [1:0]    r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_resp(input int a);
        if (a >= DEPTH) return 2'b11;
        if (a < RO)     return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_wr   = 0;
        exp_err  = 0;
        exp_last = '0;
    endtask

    // One write on the WAIT_CYCLES=2 instance; returns while ready is high.
    task automatic xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] i,
                        input logic [1:0] exp_r, input bit keep_valid, input bit from_resp);
        int lat;
        valid = 1'b1;
        addr  = a;
        data  = d;
        id    = i;
        if (from_resp) begin
            step();
            check("gap_ready_low", ready, 0);
        end
        lat = 0;
        do begin
            step();
            lat++;
        end while (!ready && lat < 20);
        check("latency", lat, WC + 2);
        if (model_resp(int'(a)) == 2'b00) begin
            mem_m[int'(a)] = d;
            exp_wr++;
        end else begin
            exp_err++;
        end
        exp_last = i;
        check("resp", resp, exp_r);
        check("last_id", last_id, exp_last);
        check("wr_count", wr_count, exp_wr);
        check("err_count", err_count, exp_err);
        check("busy_in_resp", busy, 1);
        if (!keep_valid) begin
            valid = 1'b0;
            step();
            check("ready_one_cycle", ready, 0);
            check("resp_cleared", resp, 0);
            check("busy_after", busy, 0);
        end
    endtask

    task automatic dbg_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        dbg_addr = a;
        step();
        check("dbg_data", dbg_data, exp);
    endtask

    vec_t vecs [8];

    initial begin
        int  saw_ready;
        bit  keep, prev_keep;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;

        vecs[0] = '{8'h10, 32'hDEADBEEF, 4'd3, 2'b00};
        vecs[1] = '{8'h02, 32'h00000001, 4'd4, 2'b10};
        vecs[2] = '{8'h90, 32'hCAFEF00D, 4'd5, 2'b11};
        vecs[3] = '{8'h03, 32'h00000002, 4'd6, 2'b10};
        vecs[4] = '{8'h04, 32'h0000A5A5, 4'd7, 2'b00};
        vecs[5] = '{8'h3F, 32'h12121212, 4'd8, 2'b00};
        vecs[6] = '{8'h40, 32'h0BADBEEF, 4'd9, 2'b11};
        vecs[7] = '{8'hFF, 32'hFFFFFFFF, 4'd15, 2'b11};

        rst = 1'b1;
        valid = 1'b0; addr = '0; data = '0; id = '0; dbg_addr = '0;
        valid0 = 1'b0; addr0 = '0; data0 = '0; id0 = '0; dbg_addr0 = '0;
        step();
        step();
        check("rst_ready", ready, 0);
        check("rst_resp", resp, 0);
        check("rst_last_id", last_id, 0);
        check("rst_busy", busy, 0);
        check("rst_dbg_data", dbg_data, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_ready0", ready0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int k = 0; k < 8; k++)
            xfer(vecs[k].a, vecs[k].d, vecs[k].i, vecs[k].r, 1'b0, 1'b0);
        dbg_rd(8'h10, 32'hDEADBEEF);
        dbg_rd(8'h04, 32'h0000A5A5);
        dbg_rd(8'h3F, 32'h12121212);
        dbg_rd(8'hC0, 32'h0);

        // Back-to-back with valid held high across the ready pulse.
        xfer(8'h20, 32'hA, 4'd1, 2'b00, 1'b1, 1'b0);
        xfer(8'h21, 32'hB, 4'd2, 2'b00, 1'b0, 1'b1);
        dbg_rd(8'h20, 32'hA);
        dbg_rd(8'h21, 32'hB);

        // Abort: valid dropped one cycle after acceptance.
        valid = 1'b1; addr = 8'h10; data = 32'h55555555; id = 4'd7;
        step();
        check("abort_busy_wait", busy, 1);
        valid = 1'b0;
        step();
        check("abort_perr", protocol_err, 1);
        check("abort_busy", busy, 0);
        saw_ready = 0;
        for (int k = 0; k < 5; k++) begin
            if (ready) saw_ready++;
            step();
        end
        check("abort_no_ready", saw_ready, 0);
        check("abort_wr_count", wr_count, exp_wr);
        check("abort_err_count", err_count, exp_err);
        dbg_rd(8'h10, 32'hDEADBEEF);
        xfer(8'h11, 32'h77, 4'd9, 2'b00, 1'b0, 1'b0);
        check("perr_sticky", protocol_err, 1);
        dbg_rd(8'h11, 32'h77);

        // Reset during WAIT: no write, outputs and counters cleared at once.
        xfer(8'h30, 32'h12345678, 4'd4, 2'b00, 1'b0, 1'b0);
        valid = 1'b1; addr = 8'h30; data = 32'h00000BAD; id = 4'd5;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_ready", ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_count", wr_count, 0);
        check("midrst_err_count", err_count, 0);
        check("midrst_perr", protocol_err, 0);
        valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        dbg_rd(8'h30, 32'h12345678);
        check("midrst_last_id", last_id, 0);

        // Reset while ready is high drops it immediately; the write already committed.
        xfer(8'h31, 32'h31313131, 4'd6, 2'b00, 1'b1, 1'b0);
        valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_in_resp_ready", ready, 0);
        check("rst_in_resp_resp", resp, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        dbg_rd(8'h31, 32'h31313131);

        // Random traffic against the model.
        prev_keep = 1'b0;
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 255));
            rd = $urandom;
            keep = (k == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            xfer(ra, rd, 4'($urandom_range(0, 15)), model_resp(int'(ra)), keep, prev_keep);
            prev_keep = keep;
            if (!keep) begin
                ra = AW'($urandom_range(RO, DEPTH - 1));
                if (mem_m.exists(int'(ra)))
                    dbg_rd(ra, mem_m[int'(ra)]);
            end
        end

        // Zero-wait-state instance: single-cycle latency and write/debug collision.
        valid0 = 1'b1; addr0 = 8'h20; data0 = 32'h11; id0 = 4'd1; dbg_addr0 = 8'h20;
        step();
        check("w0_ready", ready0, 1);
        check("w0_resp", resp0, 0);
        check("w0_last_id", last_id0, 1);
        check("w0_wr_count", wr_count0, 1);
        data0 = 32'h22; id0 = 4'd2;
        step();
        check("w0_gap", ready0, 0);
        check("w0_dbg_first", dbg_data0, 32'h11);
        step();
        check("w0_ready2", ready0, 1);
        check("w0_collision_old", dbg_data0, 32'h11);
        check("w0_last_id2", last_id0, 2);
        valid0 = 1'b0;
        step();
        check("w0_collision_new", dbg_data0, 32'h22);
        check("w0_ready_low", ready0, 0);
        check("w0_wr_count2", wr_count0, 2);
        valid0 = 1'b1; addr0 = 8'hC0; id0 = 4'd3;
        step();
        check("w0_decerr", resp0, 2'b11);
        check("w0_err_count", err_count0, 1);
        valid0 = 1'b0;
        step();
        check("w0_resp_cleared", resp0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
